cpu_regfile_mp: RTL

CPU_REGFILE_MP -- requirements
Module: cpu_regfile_mp

---
 rtl/cpu_regfile_mp.sv | 88 ++++++++
 1 files changed

// File: rtl/cpu_regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, write-first bypass,
// and a power-on / reset sweep that zeroes every entry before the file is usable.
module cpu_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [XLEN-1:0]         rd,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_en,
    input  logic [NREAD*ADDR_W-1:0] rs_addr,
    input  logic [NREAD-1:0]        rs_en,
    output logic [NREAD*XLEN-1:0]   rs_data,
    output logic                    ready
);
    localparam int NREGS = 2**ADDR_W;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                    ready_q, ready_d;
    logic [NREAD*XLEN-1:0]   rs_data_q, rs_data_d;
    logic [XLEN-1:0]         regs_q [NREGS];
    logic [XLEN-1:0]         regs_d [NREGS];
    logic [ADDR_W-1:0]       raddr;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        rs_data_d = rs_data_q;
        regs_d    = regs_q;
        raddr     = '0;
        case (state_q)
            ST_CLEAR: begin
                regs_d[clr_cnt_q] = '0;
                clr_cnt_d         = clr_cnt_q + 1'b1;
                rs_data_d         = '0;
                if (clr_cnt_q == ADDR_W'(NREGS-1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                if (rd_en && rd_addr != '0)
                    regs_d[rd_addr] = rd;
                // Reads see the old array, so same-cycle writes are forwarded explicitly.
                for (int p = 0; p < NREAD; p++) begin
                    if (rs_en[p]) begin
                        raddr = rs_addr[p*ADDR_W +: ADDR_W];
                        if (raddr == '0)
                            rs_data_d[p*XLEN +: XLEN] = '0;
                        else if (rd_en && rd_addr == raddr)
                            rs_data_d[p*XLEN +: XLEN] = rd;
                        else
                            rs_data_d[p*XLEN +: XLEN] = regs_q[raddr];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            rs_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            rs_data_q <= rs_data_d;
        end
    end

    // Storage has no reset of its own; the clear sweep zeroes it instead.
    always_ff @(posedge CLK) begin
        if (!RST)
            regs_q <= regs_d;
    end

    assign rs_data = rs_data_q;
    assign ready   = ready_q;
endmodule
